// File: rtl/tick_src_sel_if.sv
// tick_src_sel_if: source/mode inputs and selected tick outputs of tick_src_sel
interface tick_src_sel_if #(
    parameter int N_SRC = 4,
    parameter int SEL_W = 2
);
    logic [SEL_W-1:0] mode;
    logic [N_SRC-1:0] src;
    logic             out_level;
    logic             out_pulse;
    logic [SEL_W-1:0] active_sel;
    logic             switching;
    modport master (output mode, src, input out_level, out_pulse, active_sel, switching);
    modport slave  (input mode, src, output out_level, out_pulse, active_sel, switching);
endinterface

// File: rtl/tick_src_sel.sv
// tick_src_sel: glitch-free N-way selector of synchronised tick/level sources
module tick_src_sel #(
    parameter int N_SRC       = 4,
    parameter int SEL_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int BLANK       = 4
) (
    input logic        clk,
    input logic        rst,
    tick_src_sel_if.slave bus
);
    localparam int CW = BLANK > 1 ? $clog2(BLANK) : 1;
    localparam int NP = 2 ** SEL_W;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_BLANK, S_ARM} state_t;

    state_t                          state, n_state;
    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync;
    logic [N_SRC-1:0]                s, s_d;
    logic [NP-1:0]                   sp, sdp;
    logic [SEL_W-1:0]                act, n_act, pend, n_pend, tgt;
    logic [CW-1:0]                   cnt, n_cnt;
    logic                            lvl, n_lvl, pls, n_pls, cur, cur_d;

    assign s = sync[SYNC_STAGES-1];

    // zero-padded so any active_sel value indexes safely when N_SRC < 2**SEL_W
    always_comb begin
        sp  = '0;
        sdp = '0;
        sp[N_SRC-1:0]  = s;
        sdp[N_SRC-1:0] = s_d;
    end

    assign cur   = sp[act];
    assign cur_d = sdp[act];
    assign tgt   = 32'(bus.mode) < N_SRC ? bus.mode : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            s_d   <= '0;
            state <= S_ARM;
            act   <= '0;
            pend  <= '0;
            cnt   <= '0;
            lvl   <= 1'b0;
            pls   <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], bus.src};
            s_d   <= s;
            state <= n_state;
            act   <= n_act;
            pend  <= n_pend;
            cnt   <= n_cnt;
            lvl   <= n_lvl;
            pls   <= n_pls;
        end
    end

    always_comb begin
        n_state = state;
        n_act   = act;
        n_pend  = pend;
        n_cnt   = cnt;
        n_lvl   = 1'b0;
        n_pls   = 1'b0;
        case (state)
            S_RUN: begin
                n_lvl = cur;
                n_pls = cur & ~cur_d;
                if (tgt != act) begin
                    n_pend  = tgt;
                    n_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                n_lvl = cur;
                if (!cur) begin
                    n_cnt   = CW'(BLANK - 1);
                    n_state = S_BLANK;
                end
            end
            S_BLANK: begin
                if (tgt != pend) begin
                    n_pend = tgt;
                    n_cnt  = CW'(BLANK - 1);
                end else if (cnt == '0) begin
                    n_act   = pend;
                    n_state = S_ARM;
                end else begin
                    n_cnt = cnt - 1'b1;
                end
            end
            default: begin
                if (tgt != act) begin
                    n_pend  = tgt;
                    n_cnt   = CW'(BLANK - 1);
                    n_state = S_BLANK;
                end else if (!cur) begin
                    n_state = S_RUN;
                end
            end
        endcase
    end

    assign bus.out_level  = lvl;
    assign bus.out_pulse  = pls;
    assign bus.active_sel = act;
    assign bus.switching  = state != S_RUN;
endmodule

// File: tb/tb_tick_src_sel.sv
// tb_tick_src_sel: vector-table and directed-sequence checks of tick_src_sel
module tb_tick_src_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        logic [3:0] src;
        logic [4:0] exp;
    } vec_t;

    vec_t vq[$];

    tick_src_sel_if #(.N_SRC(4), .SEL_W(2)) bus ();
    tick_src_sel_if #(.N_SRC(3), .SEL_W(2)) b3 ();

    tick_src_sel #(.N_SRC(4), .SEL_W(2), .SYNC_STAGES(2), .BLANK(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    tick_src_sel #(.N_SRC(3), .SEL_W(2), .SYNC_STAGES(2), .BLANK(4)) dut3 (
        .clk(clk), .rst(rst), .bus(b3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {lvl,pls,sel,sw}=%b required %b", nm, got, exp);
        end
    endtask

    task automatic add(input int n, input logic [1:0] m, input logic [3:0] s,
                       input logic l, input logic p, input logic [1:0] a, input logic w);
        for (int k = 0; k < n; k++) vq.push_back('{m, s, {l, p, a, w}});
    endtask

    function automatic logic [4:0] outs();
        return {bus.out_level, bus.out_pulse, bus.active_sel, bus.switching};
    endfunction

    function automatic logic [4:0] outs3();
        return {b3.out_level, b3.out_pulse, b3.active_sel, b3.switching};
    endfunction

    initial begin
        bus.mode = '0;
        bus.src  = '0;
        b3.mode  = '0;
        b3.src   = '0;
        // normal operation on source 0, then drain/blank/arm switch to 1
        add(2, 0, 4'h0, 0, 0, 0, 0);
        add(2, 0, 4'h1, 0, 0, 0, 0);
        add(1, 0, 4'h1, 1, 1, 0, 0);
        add(1, 0, 4'h1, 1, 0, 0, 0);
        add(2, 1, 4'h1, 1, 0, 0, 1);
        add(2, 1, 4'h0, 1, 0, 0, 1);
        add(4, 1, 4'h0, 0, 0, 0, 1);
        add(1, 1, 4'h0, 0, 0, 1, 1);
        add(1, 1, 4'h0, 0, 0, 1, 0);
        // switch back to source 0 while it is already high: ARM holds
        add(5, 0, 4'h1, 0, 0, 1, 1);
        add(3, 0, 4'h1, 0, 0, 0, 1);
        add(2, 0, 4'h0, 0, 0, 0, 1);
        add(2, 0, 4'h1, 0, 0, 0, 0);
        add(1, 0, 4'h1, 1, 1, 0, 0);
        add(2, 0, 4'h0, 1, 0, 0, 0);
        add(1, 0, 4'h0, 0, 0, 0, 0);
        // retargeting during BLANK reloads the gap
        add(3, 1, 4'h0, 0, 0, 0, 1);
        add(2, 2, 4'h0, 0, 0, 0, 1);
        add(4, 3, 4'h0, 0, 0, 0, 1);
        add(1, 3, 4'h0, 0, 0, 3, 1);
        add(1, 3, 4'h0, 0, 0, 3, 0);
        // edge and mode change on the same cycle
        add(2, 3, 4'h8, 0, 0, 3, 0);
        add(1, 0, 4'h8, 1, 1, 3, 1);
        add(1, 0, 4'h8, 1, 0, 3, 1);
        add(2, 0, 4'h0, 1, 0, 3, 1);
        add(4, 0, 4'h0, 0, 0, 3, 1);
        add(1, 0, 4'h0, 0, 0, 0, 1);
        add(1, 0, 4'h0, 0, 0, 0, 0);

        step();
        step();
        chk("reset", outs(), 5'b0_0_00_1);
        rst = 1'b0;
        foreach (vq[i]) begin
            bus.mode = vq[i].mode;
            bus.src  = vq[i].src;
            step();
            chk($sformatf("row%0d", i), outs(), vq[i].exp);
        end

        // reset during BLANK with a full synchroniser
        bus.mode = 2'd2;
        step();
        chk("rst_drain", outs(), 5'b0_0_00_1);
        step();
        bus.src = 4'h1;
        step();
        step();
        chk("rst_blank", outs(), 5'b0_0_00_1);
        rst = 1'b1;
        bus.src = 4'h0;
        step();
        chk("rst_mid", outs(), 5'b0_0_00_1);
        rst = 1'b0;
        bus.mode = 2'd0;
        step();
        chk("rst_arm_run", outs(), 5'b0_0_00_0);

        // out-of-range mode on a 3-source instance falls back to source 0
        chk("n3_idle", outs3(), 5'b0_0_00_0);
        b3.mode = 2'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("n3_oor%0d", k), outs3(), 5'b0_0_00_0);
        end
        b3.mode = 2'd2;
        step();
        chk("n3_valid", outs3(), 5'b0_0_00_1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
